// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a word-wide
//               data memory with a combinational read port. Supports word
//               and byte loads/stores; byte stores use read-modify-write.
//               Out-of-range addresses fault without touching memory.
//               Optional build macro LSU_MISALIGN_CHECK_EN makes word
//               requests with addr[1:0] != 0 fault.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 29
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic        req_byte_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_fault_out,
    output logic        mem_we_out,
    output logic [7:0]  mem_addr_out,
    output logic [31:0] mem_wdata_out,
    input  logic [31:0] mem_rdata_in
);

    // FSM encoding
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_MERGE  = 2'd2;

    // ------------------------------------------------------------------------
    // State and latched request fields
    // ------------------------------------------------------------------------
    logic [1:0]  state_q,       state_d;
    logic [7:0]  waddr_q,       waddr_d;       // latched word address
    logic [1:0]  lane_q,        lane_d;        // latched byte lane
    logic [31:0] wdata_q,       wdata_d;
    logic        write_q,       write_d;
    logic        byte_q,        byte_d;
    logic        fault_q,       fault_d;
    logic [31:0] rmw_q,         rmw_d;         // word read during byte-store RMW
    logic        resp_valid_q,  resp_valid_d;
    logic [31:0] resp_rdata_q,  resp_rdata_d;
    logic        resp_fault_q,  resp_fault_d;

    logic        req_fault;
    logic        req_misalign;
    logic [31:0] load_lane;
    logic [31:0] merged_word;

    // Alignment fault only applies to word requests, and only in the checking build
`ifdef LSU_MISALIGN_CHECK_EN
    assign req_misalign = !req_byte_in && (req_addr_in[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    // Request fault: upper address bits set, word index past the implemented memory, or misaligned
    assign req_fault = (req_addr_in[31:10] != 22'd0)
                    || ({24'd0, req_addr_in[9:2]} >= MEM_WORDS)
                    || req_misalign;

    // Byte-lane extraction (little-endian) and lane replacement for byte accesses
    always_comb begin
        load_lane   = 32'd0;
        merged_word = rmw_q;
        case (lane_q)
            2'd0: begin
                load_lane         = {24'd0, mem_rdata_in[7:0]};
                merged_word[7:0]  = wdata_q[7:0];
            end
            2'd1: begin
                load_lane         = {24'd0, mem_rdata_in[15:8]};
                merged_word[15:8] = wdata_q[7:0];
            end
            2'd2: begin
                load_lane          = {24'd0, mem_rdata_in[23:16]};
                merged_word[23:16] = wdata_q[7:0];
            end
            default: begin
                load_lane          = {24'd0, mem_rdata_in[31:24]};
                merged_word[31:24] = wdata_q[7:0];
            end
        endcase
    end

    // Next-state, request latching and response generation
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        byte_d       = byte_q;
        fault_d      = fault_q;
        rmw_d        = rmw_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid_in) begin
                    waddr_d = req_addr_in[9:2];
                    lane_d  = req_addr_in[1:0];
                    wdata_d = req_wdata_in;
                    write_d = req_write_in;
                    byte_d  = req_byte_in;
                    fault_d = req_fault;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (byte_q && write_q && !fault_q) begin
                    // Byte store: capture the current word, write the merged word next cycle
                    rmw_d   = mem_rdata_in;
                    state_d = S_MERGE;
                end else begin
                    // Word ops, byte loads and all faults complete here
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_fault_d = fault_q;
                    if (!write_q && !fault_q) begin
                        resp_rdata_d = byte_q ? load_lane : mem_rdata_in;
                    end
                end
            end
            S_MERGE: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            waddr_q      <= 8'd0;
            lane_q       <= 2'd0;
            wdata_q      <= 32'd0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            fault_q      <= 1'b0;
            rmw_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            byte_q       <= byte_d;
            fault_q      <= fault_d;
            rmw_q        <= rmw_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Memory write port decoded from state; IDLE (and therefore reset) forces it off
    always_comb begin
        mem_we_out    = 1'b0;
        mem_wdata_out = 32'd0;
        case (state_q)
            S_ACCESS: begin
                if (write_q && !byte_q && !fault_q) begin
                    mem_we_out    = 1'b1;
                    mem_wdata_out = wdata_q;
                end
            end
            S_MERGE: begin
                mem_we_out    = 1'b1;
                mem_wdata_out = merged_word;
            end
            default: begin
                mem_we_out    = 1'b0;
                mem_wdata_out = 32'd0;
            end
        endcase
    end

    assign req_ready_out  = (state_q == S_IDLE);
    assign mem_addr_out   = waddr_q;
    assign resp_valid_out = resp_valid_q;
    assign resp_rdata_out = resp_rdata_q;
    assign resp_fault_out = resp_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit. Expected responses and
//               memory writes are queued at request acceptance from a
//               reference memory and compared when the DUT produces them.
//               Honours LSU_MISALIGN_CHECK_EN for the expected fault rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TB_WORDS = 29;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } resp_exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic        clk = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic        req_byte_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_fault_out;
    logic        mem_we_out;
    logic [7:0]  mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;

    logic [31:0] mem       [256];
    logic [31:0] model_mem [256];
    logic        mem_init_done = 1'b0;
    logic        sb_en = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    resp_exp_t resp_q[$];
    wr_exp_t   wr_q[$];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(TB_WORDS)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_write_in  (req_write_in),
        .req_byte_in   (req_byte_in),
        .req_addr_in   (req_addr_in),
        .req_wdata_in  (req_wdata_in),
        .resp_valid_out(resp_valid_out),
        .resp_rdata_out(resp_rdata_out),
        .resp_fault_out(resp_fault_out),
        .mem_we_out    (mem_we_out),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .mem_rdata_in  (mem_rdata_in)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h1122_3344;
        return {i[7:0], ~i[7:0], 8'h5A, 8'(i * 3)};
    endfunction

    // Data memory model: combinational read, clocked write
    assign mem_rdata_in = mem[mem_addr_out];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (mem_we_out) begin
            mem[mem_addr_out] <= mem_wdata_out;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one accepted request
    task automatic push_expect(input logic w, input logic b, input logic [31:0] a,
                               input logic [31:0] d, input int acc);
        resp_exp_t   e;
        wr_exp_t     we;
        logic        f;
        logic [7:0]  wi;
        logic [1:0]  ln;
        logic [31:0] word;
        wi = a[9:2];
        ln = a[1:0];
        f  = (a[31:10] != 22'd0) || (int'(wi) >= TB_WORDS);
`ifdef LSU_MISALIGN_CHECK_EN
        if (!b && ln != 2'd0) f = 1'b1;
`endif
        e.fault = f;
        e.acc   = acc;
        e.rdata = 32'd0;
        e.lat   = 2;
        word    = model_mem[wi];
        if (!f) begin
            if (!w) begin
                e.rdata = b ? {24'd0, word[8*ln +: 8]} : word;
            end else if (b) begin
                word[8*ln +: 8] = d[7:0];
                model_mem[wi] = word;
                we.addr = wi;
                we.data = word;
                wr_q.push_back(we);
                e.lat = 3;
            end else begin
                model_mem[wi] = d;
                we.addr = wi;
                we.data = d;
                wr_q.push_back(we);
            end
        end
        resp_q.push_back(e);
    endtask

    // Scoreboard: compare responses and memory writes as they appear
    always @(negedge clk) begin : sb_mon
        resp_exp_t e;
        wr_exp_t   we;
        if (sb_en && rst_n_in) begin
            if (resp_valid_out) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_rdata", resp_rdata_out, e.rdata);
                    check("resp_fault", {31'd0, resp_fault_out}, {31'd0, e.fault});
                    check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            if (mem_we_out) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", {24'd0, mem_addr_out}, {24'd0, we.addr});
                    check("wr_data", mem_wdata_out, we.data);
                end
            end
        end
    end

    // Present one request and hold it until accepted; valid stays high afterwards
    task automatic send(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, output int acc);
        logic accepted;
        accepted = 1'b0;
        acc = -1;
        @(negedge clk);
        req_write_in = w;
        req_byte_in  = b;
        req_addr_in  = a;
        req_wdata_in = d;
        req_valid_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (req_ready_out) begin
                acc = cyc;
                push_expect(w, b, a, d, cyc);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (resp_q.size() == 0 && wr_q.size() == 0) break;
        end
        check("drain_empty", 32'(resp_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin : main
        int a0, a1;
        logic [31:0] addr;
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        rst_n_in     = 1'b1;
        req_valid_in = 1'b0;
        req_write_in = 1'b0;
        req_byte_in  = 1'b0;
        req_addr_in  = 32'd0;
        req_wdata_in = 32'd0;

        // Reset values
        #1 rst_n_in = 1'b0;
        #2;
        check("rst_ready",      {31'd0, req_ready_out},  32'd1);
        check("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
        check("rst_resp_rdata", resp_rdata_out,          32'd0);
        check("rst_resp_fault", {31'd0, resp_fault_out}, 32'd0);
        check("rst_mem_we",     {31'd0, mem_we_out},     32'd0);
        check("rst_mem_addr",   {24'd0, mem_addr_out},   32'd0);
        check("rst_mem_wdata",  mem_wdata_out,           32'd0);
        repeat (3) @(negedge clk);
        rst_n_in = 1'b1;
        #1 check("ready_after_rst", {31'd0, req_ready_out}, 32'd1);

        // Word store then word load
        send(1'b1, 1'b0, 32'h08, 32'hDEAD_BEEF, a0);
        idle();
        send(1'b0, 1'b0, 32'h08, 32'd0, a0);
        idle();
        drain();

        // Byte store read-modify-write into word 1, then readbacks
        send(1'b1, 1'b1, 32'h06, 32'h0000_00AA, a0);
        idle();
        send(1'b0, 1'b1, 32'h06, 32'd0, a0);
        send(1'b0, 1'b0, 32'h04, 32'd0, a0);
        idle();
        drain();

        // Faulting requests: past last word, high address bits, byte store out of range
        send(1'b0, 1'b0, 32'h74, 32'd0, a0);
        send(1'b0, 1'b0, 32'h400, 32'd0, a0);
        send(1'b1, 1'b1, 32'h400, 32'h55, a0);
        send(1'b1, 1'b0, 32'h70, 32'h1234_5678, a0);
        idle();
        drain();

        // Misaligned word load, and misaligned byte load never faults
        send(1'b0, 1'b0, 32'h05, 32'd0, a0);
        send(1'b0, 1'b1, 32'h07, 32'd0, a0);
        idle();
        drain();

        // Four back-to-back word loads with valid held high
        send(1'b0, 1'b0, 32'h00, 32'd0, a0);
        for (int k = 1; k < 4; k++) begin
            send(1'b0, 1'b0, 32'(4 * k), 32'd0, a1);
            check("b2b_gap", 32'(a1 - a0), 32'd2);
            a0 = a1;
        end
        idle();
        drain();

        // Every byte lane of word 5, then the whole word
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 1'b1, 32'(20 + k), 32'(8'h10 + k), a0);
        end
        send(1'b0, 1'b0, 32'h14, 32'd0, a0);
        idle();
        drain();

        // Random mix of loads and stores, including faults
        for (int k = 0; k < 40; k++) begin
            addr = {21'd0, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                    8'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom, a0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();

        // Reset during MERGE of a byte store aborts it
        sb_en = 1'b0;
        @(negedge clk);
        req_write_in = 1'b1;
        req_byte_in  = 1'b1;
        req_addr_in  = 32'h0E;
        req_wdata_in = 32'h77;
        req_valid_in = 1'b1;
        check("abort_ready", {31'd0, req_ready_out}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_in = 1'b0;
        check("abort_access_we", {31'd0, mem_we_out}, 32'd0);
        @(negedge clk);
        check("abort_merge_we", {31'd0, mem_we_out}, 32'd1);
        #1 rst_n_in = 1'b0;
        #1;
        check("abort_we_drop",    {31'd0, mem_we_out},     32'd0);
        check("abort_resp_valid", {31'd0, resp_valid_out}, 32'd0);
        check("abort_mem_addr",   {24'd0, mem_addr_out},   32'd0);
        check("abort_mem_wdata",  mem_wdata_out,           32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("abort_no_resp", {31'd0, resp_valid_out}, 32'd0);
            @(negedge clk);
        end
        check("abort_mem_kept", mem[3], model_mem[3]);
        check("abort_ready_after", {31'd0, req_ready_out}, 32'd1);
        sb_en = 1'b1;

        // Unit keeps working after the abort
        send(1'b0, 1'b0, 32'h0C, 32'd0, a0);
        send(1'b0, 1'b1, 32'h0E, 32'd0, a0);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 29: number of implemented data-memory words; valid word addresses are 0..MEM_WORDS-1.
REQ-002 SHALL use one clock, clk_in; reset is rst_n_in, asynchronous, active-low.
REQ-003 clk_in  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n_in  input  1  asynchronous active-low reset.
REQ-005 req_valid_in  input  1  pipeline presents a memory request.
REQ-006 req_ready_out  output  1  unit accepts a request this cycle.
REQ-007 req_write_in  input  1  1 = store, 0 = load.
REQ-008 req_byte_in  input  1  1 = byte access, 0 = word access.
REQ-009 req_addr_in  input  32  byte address.
REQ-010 req_wdata_in  input  32  store data; byte stores use bits [7:0].
REQ-011 resp_valid_out  output  1  one-cycle completion pulse.
REQ-012 resp_rdata_out  output  32  load result; valid while resp_valid_out=1.
REQ-013 resp_fault_out  output  1  request faulted; valid while resp_valid_out=1.
REQ-014 mem_we_out  output  1  data-memory write enable.
REQ-015 mem_addr_out  output  8  data-memory word address.
REQ-016 mem_wdata_out  output  32  data-memory write data.
REQ-017 mem_rdata_in  input  32  data-memory combinational read data for mem_addr_out.

Function
REQ-018 SHALL implement the FSM states IDLE, ACCESS and MERGE, with req_ready_out=1 only in IDLE.
REQ-019 A request SHALL be accepted on a rising edge where req_valid_in=1 and req_ready_out=1; addr, wdata, write and byte fields are latched, and the FSM moves IDLE->ACCESS.
REQ-020 Word address SHALL be latched addr[9:2]; mem_addr_out SHALL be driven from the latched word address in ACCESS and MERGE.
REQ-021 Fault SHALL be flagged when addr[31:10]!=0 or addr[9:2]>=MEM_WORDS; a faulting request never asserts mem_we_out, gives resp_rdata_out=0, and follows word-op timing.
REQ-022 In ACCESS, a word store SHALL assert mem_we_out with mem_wdata_out = latched wdata.
REQ-023 A word load SHALL register resp_rdata_out = mem_rdata_in at the ACCESS-exit edge.
REQ-024 A byte load SHALL return byte lane addr[1:0] (lane k = bits[8k+7:8k], little-endian), zero-extended.
REQ-025 A byte store SHALL perform read-modify-write:
- in ACCESS, mem_we_out=0 and the read word is latched; ACCESS->MERGE.
- in MERGE, mem_we_out=1 and mem_wdata_out = read word with lane addr[1:0] replaced by wdata[7:0]; MERGE->IDLE.
REQ-026 Word ops and faults SHALL go ACCESS->IDLE.
REQ-027 resp_valid_out SHALL pulse high for exactly one cycle, in the cycle after the final state:
- latency is 2 cycles from the accept edge for word ops and faults.
- latency is 3 cycles from the accept edge for byte stores.
REQ-028 Back-to-back requests SHALL be allowed: a new request may be accepted in the same cycle resp_valid_out is high.
REQ-029 mem_we_out SHALL be decoded combinationally from state and is never high in IDLE.
REQ-030 Stores SHALL return resp_rdata_out=0.
REQ-031 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-032 Reset assertion SHALL force state IDLE and set resp_valid_out=0, resp_rdata_out=0, resp_fault_out=0, mem_addr_out=0, mem_wdata_out=0 and mem_we_out=0 immediately, without waiting for a clock edge.
REQ-033 Reset during ACCESS or MERGE SHALL abort the request with no write and no response.
REQ-034 req_ready_out SHALL be 1 after reset.

Configuration
REQ-035 With LSU_MISALIGN_CHECK_EN defined, a word request with addr[1:0]!=0 SHALL fault.
REQ-036 Without LSU_MISALIGN_CHECK_EN, addr[1:0] SHALL be ignored for word requests.
REQ-037 Byte requests SHALL never fault on alignment in either build.

Verification
REQ-038 Word store 0xDEADBEEF to 0x08, then word load 0x08 -> mem_we_out one cycle at address 2; load returns 0xDEADBEEF with resp_valid_out 2 cycles after accept.
REQ-039 Memory word 1 = 0x11223344; byte store 0xAA to 0x06 -> write 0x11AA3344 at address 1 in MERGE; resp_valid_out 3 cycles after accept; byte load 0x06 -> 0x000000AA.
REQ-040 Load from 0x74 (word 29) and from 0x400 -> resp_fault_out=1, resp_rdata_out=0, mem_we_out never asserted.
REQ-041 Word load from 0x05 -> with LSU_MISALIGN_CHECK_EN, fault; without it, returns word 1.
REQ-042 Assert rst_n_in during MERGE of a byte store -> mem_we_out drops immediately, memory is unchanged, no resp_valid_out, and req_ready_out=1 after release.
REQ-043 Hold req_valid_in high for 4 consecutive word loads -> accepts on every IDLE cycle; 4 resp_valid_out pulses with correct data, in order.
